// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 types, frame constants and the parity helper.
package ps2_pkg;
  typedef enum logic [1:0] {RX_IDLE, RX_RECV, RX_STOP} rx_state_e;
  localparam int PS2_DATA_BITS  = 8;
  localparam int PS2_FRAME_BITS = 11;
  function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] d);
    return ~^d;
  endfunction
endpackage

// File: rtl/ps2_sync.sv
// ps2_sync: 2-flop synchroniser with a configurable reset value.
module ps2_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic d,
  output logic q
);
  logic [1:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[0], d};
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) sync_q <= {2{RST_VAL}};
    else            sync_q <= sync_d;
  assign q = sync_q[1];
endmodule

// File: rtl/ps2_host_rx.sv
// ps2_host_rx: PS/2 device-to-host frame receiver with a one-deep valid/ready holding register.
module ps2_host_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       ps2_clk_negedge,
  input  logic       ps2_data,
  input  logic       tx_busy,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       err_parity,
  output logic       err_frame,
  output logic       err_overrun,
  output logic       busy
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  rx_state_e state_q, state_d;
  logic [8:0] shift_q, shift_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [TW-1:0] tmo_q, tmo_d, tmo_next;
  logic [7:0] rx_data_q, rx_data_d;
  logic rx_valid_q, rx_valid_d;
  logic err_parity_q, err_parity_d, err_frame_q, err_frame_d, err_overrun_q, err_overrun_d;
  logic data_s, good;

  ps2_sync #(.RST_VAL(1'b1)) u_data_sync (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .d(ps2_data), .q(data_s)
  );

  assign tmo_next = tmo_q + TW'(1);

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    tmo_d         = tmo_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q & ~rx_ready;
    err_parity_d  = 1'b0;
    err_frame_d   = 1'b0;
    err_overrun_d = 1'b0;
    good          = 1'b0;
    if (tx_busy) state_d = RX_IDLE;
    else case (state_q)
      RX_IDLE: if (ps2_clk_negedge && !data_s) begin
        state_d   = RX_RECV;
        bit_cnt_d = '0;
        tmo_d     = '0;
      end
      RX_RECV: if (ps2_clk_negedge) begin
        shift_d   = {data_s, shift_q[8:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
        tmo_d     = '0;
        state_d   = (bit_cnt_q == 4'd8) ? RX_STOP : RX_RECV;
      end else if (tmo_next == TW'(TIMEOUT_CYCLES)) begin
        state_d     = RX_IDLE;
        err_frame_d = 1'b1;
      end else tmo_d = tmo_next;
      RX_STOP: if (ps2_clk_negedge) begin
        state_d      = RX_IDLE;
        err_frame_d  = !data_s;
        err_parity_d = data_s && (shift_q[8] != odd_parity(shift_q[7:0]));
        good         = data_s && (shift_q[8] == odd_parity(shift_q[7:0]));
      end else if (tmo_next == TW'(TIMEOUT_CYCLES)) begin
        state_d     = RX_IDLE;
        err_frame_d = 1'b1;
      end else tmo_d = tmo_next;
      default: state_d = RX_IDLE;
    endcase
    // A full register only takes a new byte if the old one leaves this same cycle.
    if (good && (!rx_valid_q || rx_ready)) begin
      rx_data_d  = shift_q[7:0];
      rx_valid_d = 1'b1;
    end
    err_overrun_d = good && rx_valid_q && !rx_ready;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state_q       <= RX_IDLE;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      tmo_q         <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      err_parity_q  <= 1'b0;
      err_frame_q   <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      tmo_q         <= tmo_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      err_parity_q  <= err_parity_d;
      err_frame_q   <= err_frame_d;
      err_overrun_q <= err_overrun_d;
    end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign err_parity  = err_parity_q;
  assign err_frame   = err_frame_q;
  assign err_overrun = err_overrun_q;
  assign busy        = (state_q != RX_IDLE);
endmodule

// File: tb/tb_ps2_host_rx.sv
// tb_ps2_host_rx: directed frames with an event scoreboard for received bytes and error pulses.
module tb_ps2_host_rx;
  localparam int TMO = 50;
  localparam int EV_VALID = 0, EV_PAR = 1, EV_FRM = 2, EV_OVR = 3;

  typedef struct {int kind; logic [7:0] data;} ev_t;

  logic sys_clk = 1'b0, sys_rst_n = 1'b0;
  logic ps2_clk_negedge = 1'b0, ps2_data = 1'b1, tx_busy = 1'b0, rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic rx_valid, err_parity, err_frame, err_overrun, busy;
  logic prev_valid = 1'b0;
  int vectors = 0, errors = 0;
  ev_t exp_q[$];

  ps2_host_rx #(.TIMEOUT_CYCLES(TMO)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .ps2_clk_negedge(ps2_clk_negedge),
    .ps2_data(ps2_data), .tx_busy(tx_busy), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .err_parity(err_parity), .err_frame(err_frame),
    .err_overrun(err_overrun), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_ev(input int k, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic got_ev(input int k, input logic [7:0] d);
    ev_t e;
    if (exp_q.size() == 0) chk("unexpected_event", k, 32'hFF);
    else begin
      e = exp_q.pop_front();
      chk("event_kind", k, e.kind);
      if (k == EV_VALID) chk("rx_data_on_valid", d, e.data);
    end
  endtask

  always @(negedge sys_clk) begin
    if (!sys_rst_n) prev_valid = 1'b0;
    else begin
      if (rx_valid && !prev_valid) got_ev(EV_VALID, rx_data);
      if (err_parity) got_ev(EV_PAR, 8'h00);
      if (err_frame) got_ev(EV_FRM, 8'h00);
      if (err_overrun) got_ev(EV_OVR, 8'h00);
      prev_valid = rx_valid;
    end
  end

  task automatic send_bit(input logic b);
    @(posedge sys_clk); #1 ps2_data = b;
    repeat (3) @(posedge sys_clk);
    #1 ps2_clk_negedge = 1'b1;
    @(posedge sys_clk); #1 ps2_clk_negedge = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    send_bit(1'b0);
    chk("busy_after_start", busy, 1'b1);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stop);
    chk("busy_after_stop", busy, 1'b0);
    ps2_data = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] d);
    send_frame(d, ~^d, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_errs", {err_parity, err_frame, err_overrun}, 3'b000);
    sys_rst_n = 1'b1;
    idle(2);

    send_bit(1'b1);
    chk("glitch_busy", busy, 1'b0);

    expect_ev(EV_VALID, 8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1);
    chk("good_valid_high", rx_valid, 1'b1);
    chk("good_data", rx_data, 8'h1C);
    idle(1);
    chk("good_valid_one_cycle", rx_valid, 1'b0);

    expect_ev(EV_PAR, 8'h00);
    send_frame(8'hAA, 1'b0, 1'b1);
    idle(2);
    chk("par_valid", rx_valid, 1'b0);
    chk("par_data_kept", rx_data, 8'h1C);

    expect_ev(EV_FRM, 8'h00);
    send_frame(8'h55, 1'b1, 1'b0);
    idle(2);
    chk("frm_busy", busy, 1'b0);
    chk("frm_valid", rx_valid, 1'b0);

    rx_ready = 1'b0;
    expect_ev(EV_VALID, 8'hF0);
    send_good(8'hF0);
    expect_ev(EV_OVR, 8'h00);
    send_good(8'h12);
    idle(3);
    chk("ovr_data_held", rx_data, 8'hF0);
    chk("ovr_valid_held", rx_valid, 1'b1);
    rx_ready = 1'b1;
    idle(1);
    chk("ovr_valid_cleared", rx_valid, 1'b0);

    expect_ev(EV_FRM, 8'h00);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    ps2_data = 1'b1;
    idle(TMO - 1);
    chk("tmo_not_early", err_frame, 1'b0);
    chk("tmo_busy_before", busy, 1'b1);
    idle(1);
    chk("tmo_err_frame", err_frame, 1'b1);
    chk("tmo_busy_after", busy, 1'b0);
    idle(3);
    expect_ev(EV_VALID, 8'h1C);
    send_good(8'h1C);
    idle(2);
    chk("tmo_next_data", rx_data, 8'h1C);

    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    @(posedge sys_clk); #1 tx_busy = 1'b1;
    idle(1);
    chk("txb_busy", busy, 1'b0);
    send_bit(1'b0);
    chk("txb_strobe_ignored", busy, 1'b0);
    idle(TMO + 5);
    tx_busy = 1'b0;
    ps2_data = 1'b1;
    idle(2);
    expect_ev(EV_VALID, 8'h1C);
    send_good(8'h1C);
    idle(2);
    chk("txb_next_data", rx_data, 8'h1C);

    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    ps2_data = 1'b1;
    sys_rst_n = 1'b0;
    idle(2);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_data", rx_data, 8'h00);
    sys_rst_n = 1'b1;
    idle(TMO + 10);
    expect_ev(EV_VALID, 8'h1C);
    send_good(8'h1C);
    idle(3);
    chk("rstmid_next_data", rx_data, 8'h1C);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/ps2_host_rx.md
# ps2_host_rx

Receiver half of the PS/2 host controller: deserialises device-to-host frames from the ps2_data line and presents each received byte through a one-deep holding register with a valid/ready handshake. It is clocked by the single system clock and samples data on falling-edge strobes from the shared PS/2 clock conditioner. It sits beside the host transmitter and yields to it: while the transmitter is busy the receiver is held idle. Parity, framing and inter-edge timeout errors are reported as single-cycle pulses.

## Interface
- TIMEOUT_CYCLES, 10000: max sys_clk cycles between consecutive ps2 clock falling edges inside a frame (200 µs at 50 MHz); counter width is $clog2(TIMEOUT_CYCLES+1).
- sys_clk  in  1  system clock; all logic on its rising edge.
- sys_rst_n  in  1  reset, asynchronous assert, active-low.
- ps2_clk_negedge  in  1  one-cycle strobe per ps2_clk falling edge, from the shared conditioner.
- ps2_data  in  1  raw PS/2 data pin; synchronised internally.
- tx_busy  in  1  host transmitter active; forces abort and idle.
- rx_data  out  8  received byte, valid while rx_valid=1.
- rx_valid  out  1  holding register full.
- rx_ready  in  1  consumer accepts rx_data when rx_valid & rx_ready.
- err_parity  out  1  one-cycle pulse: odd-parity check failed.
- err_frame  out  1  one-cycle pulse: bad stop bit or inter-edge timeout.
- err_overrun  out  1  one-cycle pulse: good frame dropped because holding register full.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- Frame: start(0), D0..D7 LSB first, odd parity, stop(1); each bit sampled on a ps2_clk_negedge strobe using the synchronised data.
- ps2_data passes through a 2-flop synchroniser, reset value 1.
- States: IDLE, RECV, STOP.
  - IDLE: strobe with data=0 -> RECV, bit_cnt=0, timeout counter cleared. Strobe with data=1 -> stay IDLE, no error (glitch ignored).
  - RECV: each strobe shifts data into shift[8:0] (right shift; D0 ends in bit 0), bit_cnt++. After the 9th bit (parity) -> STOP.
  - STOP: strobe samples stop bit -> IDLE. Stop=0 -> err_frame. Stop=1 and ^{shift} = 0 (even total of data+parity ones) -> err_parity. Otherwise the frame is good.
- Good frame: if rx_valid=0, or rx_valid=1 with rx_ready=1 in the same cycle, load rx_data and set rx_valid. Otherwise drop the new byte, keep the old one, and pulse err_overrun.
- Handshake: rx_valid stays high until rx_valid & rx_ready. rx_data is stable while rx_valid=1.
- Timeout: in RECV/STOP the counter increments each cycle and clears on every strobe. Reaching TIMEOUT_CYCLES -> IDLE and pulse err_frame; partial data is discarded.
- tx_busy=1: state forced to IDLE, strobes ignored, no error pulses. The holding register is unaffected.
- Parity and frame errors never touch rx_data or rx_valid.

## Timing
- Reset values: rx_data=0x00, rx_valid=0, err_*=0, busy=0, state IDLE, sync flops=1.
- Latency: rx_valid rises the cycle after the strobe that samples the stop bit. Error pulses occur in that same cycle.
- busy rises the cycle after the start-bit strobe and falls the cycle after the stop strobe or timeout.
- Timeout abort occurs exactly TIMEOUT_CYCLES cycles after the last strobe.
- Reset mid-frame: immediate return to IDLE; the partial frame is lost with no pulse after release.
- tx_busy and a strobe in the same cycle: tx_busy wins.

## Structure
- ps2_pkg:
  - rx state enum.
  - Constants PS2_DATA_BITS=8 and PS2_FRAME_BITS=11.
  - Odd-parity function, shared with the transmitter.
- Sub-module ps2_sync: generic 2-flop synchroniser with a reset-value parameter, reused for ps2_clk in the conditioner.
- Everything else (FSM, shift register, bit counter, timeout counter, holding register) is flat in ps2_host_rx.

## Test plan
- Frame 0x1C (parity 0, stop 1), rx_ready=1 -> rx_data=0x1C, rx_valid for 1 cycle, no errors.
- Frame 0xAA with parity bit 0 -> err_parity pulse, rx_valid stays 0, rx_data unchanged.
- Frame 0x55 with stop bit 0 -> err_frame pulse, back to IDLE, busy=0.
- Two good frames 0xF0 then 0x12 with rx_ready=0 -> rx_data=0xF0 held, err_overrun on the second frame. Raising rx_ready then clears rx_valid.
- Four bits sent, then the clock stops -> err_frame exactly TIMEOUT_CYCLES after the last strobe. A following 0x1C frame is received correctly.
- tx_busy asserted mid-frame, or sys_rst_n pulsed mid-frame -> IDLE, no pulses. The next full frame 0x1C is received correctly.
